// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Lock counter must be able to hold MAXLOCK itself.
  function automatic int lock_cnt_w(input int maxlock);
    return $clog2(maxlock + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int W = 8,
  parameter int A = 8
);
  // Handshake: a transaction is accepted at a posedge where Req && Gnt. Gnt is
  // combinational and may drop while Req is held; Rvalid pulses one cycle after
  // an accepted read, and writes never produce Rvalid.
  logic         Req;
  logic         We;
  logic [A-1:0] Addr;
  logic [W-1:0] Wdata;
  logic         Lock;
  logic         Gnt;
  logic         Rvalid;
  logic [W-1:0] Rdata;

  modport master (
    output Req, We, Addr, Wdata, Lock,
    input  Gnt, Rvalid, Rdata
  );

  modport slave (
    input  Req, We, Addr, Wdata, Lock,
    output Gnt, Rvalid, Rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core (port 0) and the
// loader/DMA (port 1), with a bounded lock for bursts and registered read data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int W       = 8,
  parameter int A       = 8,
  parameter int MAXLOCK = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  dmem_arbiter_if.slave p0,
  dmem_arbiter_if.slave p1,
  output logic          MemWriteEn,
  output logic [A-1:0]  MemAddress,
  output logic [W-1:0]  MemDataIn,
  input  logic [W-1:0]  MemDataOut,
  output arb_state_t    DbgState
);

  localparam int CW = lock_cnt_w(MAXLOCK);

  arb_state_t    state;
  logic          last_gnt;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_inc;
  logic          gnt0, gnt1;
  logic          acc, acc_lock;
  logic          rd0, rd1;
  logic          rvalid0, rvalid1;
  logic [W-1:0]  rdata0, rdata1;

  // last_gnt = 1 means port 1 won most recently, so port 0 wins the next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (Reset) begin
      case (state)
        OWN0:    gnt0 = p0.Req;
        OWN1:    gnt1 = p1.Req;
        default: begin
          if (p0.Req && p1.Req) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = p0.Req;
            gnt1 = p1.Req;
          end
        end
      endcase
    end
  end

  always_comb begin
    MemWriteEn = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    if (gnt0) begin
      MemWriteEn = p0.We;
      MemAddress = p0.Addr;
      MemDataIn  = p0.Wdata;
    end else if (gnt1) begin
      MemWriteEn = p1.We;
      MemAddress = p1.Addr;
      MemDataIn  = p1.Wdata;
    end
  end

  assign acc      = gnt0 || gnt1;
  assign acc_lock = gnt0 ? p0.Lock : (gnt1 && p1.Lock);
  assign cnt_inc  = lock_cnt + 1'b1;
  assign rd0      = gnt0 && !p0.We;
  assign rd1      = gnt1 && !p1.We;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      rvalid0 <= rd0;
      rvalid1 <= rd1;
      if (rd0) rdata0 <= MemDataOut;
      if (rd1) rdata1 <= MemDataOut;

      if (acc) begin
        last_gnt <= gnt1;
        // The locked transaction that reaches MAXLOCK releases ownership.
        if (acc_lock && (cnt_inc != CW'(MAXLOCK))) begin
          state    <= gnt1 ? OWN1 : OWN0;
          lock_cnt <= cnt_inc;
        end else begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      end else begin
        state    <= IDLE;
        lock_cnt <= '0;
      end
    end
  end

  assign p0.Gnt    = gnt0;
  assign p1.Gnt    = gnt1;
  assign p0.Rvalid = rvalid0;
  assign p1.Rvalid = rvalid1;
  assign p0.Rdata  = rdata0;
  assign p1.Rdata  = rdata1;
  assign DbgState  = state;

endmodule
